// File: rtl/fft_reorder8.sv
// Reorders 8-point SDF FFT frames from bit-reversed to natural bin order
// through a ping-pong pair of 8-entry banks.
module fft_reorder8 #(
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [2:0]    out_index,
  output logic          out_last,
  output logic          frame_err
);

  typedef enum logic {R_IDLE, R_READ} state_t;

  logic [DW-1:0] mem [2][8];
  logic [1:0]    full;
  logic [2:0]    wr_cnt, wr_cnt_nxt, wr_addr;
  logic          wr_bank, wr_en, err_set, frame_done;
  logic [2:0]    rd_cnt;
  logic          rd_bank, rd_other, pick, rd_done;
  state_t        state;

  // Write decision: discard strays, restart on early sof, refuse a full bank.
  always_comb begin
    wr_en      = 1'b0;
    wr_addr    = '0;
    err_set    = 1'b0;
    wr_cnt_nxt = wr_cnt;
    frame_done = 1'b0;
    if (in_valid) begin
      if (!in_sof && wr_cnt == 3'd0) begin
        err_set = 1'b1;
      end else if (full[wr_bank]) begin
        err_set = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (in_sof) begin
          err_set    = (wr_cnt != 3'd0);
          wr_addr    = '0;
          wr_cnt_nxt = 3'd1;
        end else begin
          wr_addr    = {wr_cnt[0], wr_cnt[1], wr_cnt[2]};
          wr_cnt_nxt = wr_cnt + 3'd1;
          frame_done = (wr_cnt == 3'd7);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= in_data;
  end

  assign rd_other = ~rd_bank;
  assign pick     = full[~wr_bank] ? ~wr_bank : wr_bank;
  assign rd_done  = (state == R_READ) && (rd_cnt == 3'd7);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      full      <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_cnt <= wr_cnt_nxt;
      if (err_set) frame_err <= 1'b1;
      if (rd_done) full[rd_bank] <= 1'b0;
      if (frame_done) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
    end
  end

  // X[0] is issued on the idle->read edge so the first output lands one
  // cycle after the frame completes; rd_cnt then points at the next bin.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= R_IDLE;
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      out_last <= 1'b0;
      case (state)
        R_IDLE: begin
          if (full != 2'b00) begin
            rd_bank   <= pick;
            out_data  <= mem[pick][0];
            out_index <= '0;
            out_valid <= 1'b1;
            rd_cnt    <= 3'd1;
            state     <= R_READ;
          end else begin
            out_valid <= 1'b0;
          end
        end
        R_READ: begin
          out_data  <= mem[rd_bank][rd_cnt];
          out_index <= rd_cnt;
          out_valid <= 1'b1;
          out_last  <= (rd_cnt == 3'd7);
          rd_cnt    <= rd_cnt + 3'd1;
          if (rd_cnt == 3'd7) begin
            if (full[rd_other]) rd_bank <= rd_other;
            else                state   <= R_IDLE;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_reorder8.sv
// Directed bench for fft_reorder8: single, back-to-back, gapped, restarted
// and reset-interrupted frames against hand-computed bin orders.
module tb_fft_reorder8;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid, in_sof;
  logic [DW-1:0] in_data;
  logic          out_valid, out_last, frame_err;
  logic [DW-1:0] out_data;
  logic [2:0]    out_index;

  int checks = 0;
  int errors = 0;

  // Input sample offsets in natural output order (bit-reversed j).
  int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  logic [DW-1:0] bases [3] = '{24'h000100, 24'h000200, 24'hFFFF00};

  fft_reorder8 #(.DW(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [DW-1:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int k, input logic [DW-1:0] d);
    chk($sformatf("valid[%0d]", k), {31'b0, out_valid}, 32'd1);
    chk($sformatf("index[%0d]", k), {29'b0, out_index}, k);
    chk($sformatf("data[%0d]", k), {8'b0, out_data}, {8'b0, d});
    chk($sformatf("last[%0d]", k), {31'b0, out_last}, (k == 7) ? 32'd1 : 32'd0);
  endtask

  task automatic send_frame(input logic [DW-1:0] base);
    for (int j = 0; j < 8; j++) drive(1'b1, j == 0, base + DW'(j));
  endtask

  task automatic drain_frame(input logic [DW-1:0] base);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, '0);
      expect_out(k, base + DW'(br[k]));
    end
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", {8'b0, out_data}, 32'd0);
    chk("rst_err", {31'b0, frame_err}, 32'd0);
    rstn = 1'b1;
    drive(1'b0, 1'b0, '0);

    // Single frame, latency one cycle after the last input.
    send_frame(24'd100);
    chk("lat_valid", {31'b0, out_valid}, 32'd0);
    drain_frame(24'd100);
    drive(1'b0, 1'b0, '0);
    chk("idle_valid", {31'b0, out_valid}, 32'd0);
    chk("hold_data", {8'b0, out_data}, 32'd107);
    chk("hold_index", {29'b0, out_index}, 32'd7);

    // Three back-to-back frames, outputs overlap inputs.
    for (int c = 0; c < 32; c++) begin
      if (c < 24) drive(1'b1, (c % 8) == 0, bases[c / 8] + DW'(c % 8));
      else        drive(1'b0, 1'b0, '0);
      if (c >= 8) expect_out((c - 8) % 8, bases[(c - 8) / 8] + DW'(br[(c - 8) % 8]));
    end
    drive(1'b0, 1'b0, '0);
    chk("b2b_end_valid", {31'b0, out_valid}, 32'd0);

    // Gaps inside a frame.
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, j == 0, 24'd100 + DW'(j));
      chk($sformatf("gap_valid[%0d]", j), {31'b0, out_valid}, 32'd0);
      if (j == 2 || j == 5) begin
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        chk($sformatf("gap_idle[%0d]", j), {31'b0, out_valid}, 32'd0);
      end
    end
    drain_frame(24'd100);
    drive(1'b0, 1'b0, '0);
    chk("gap_err", {31'b0, frame_err}, 32'd0);

    // Partial frame abandoned by an early sof.
    for (int j = 0; j < 4; j++) drive(1'b1, j == 0, 24'd50 + DW'(j));
    send_frame(24'd200);
    chk("restart_err", {31'b0, frame_err}, 32'd1);
    chk("restart_lat", {31'b0, out_valid}, 32'd0);
    drain_frame(24'd200);
    drive(1'b0, 1'b0, '0);
    chk("restart_end", {31'b0, out_valid}, 32'd0);

    // Reset asserted while X[3] is presented.
    send_frame(24'd100);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, '0);
      expect_out(k, 24'd100 + DW'(br[k]));
    end
    rstn = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_data", {8'b0, out_data}, 32'd0);
    chk("arst_index", {29'b0, out_index}, 32'd0);
    chk("arst_err", {31'b0, frame_err}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    drive(1'b0, 1'b0, '0);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
    send_frame(24'd100);
    drain_frame(24'd100);

    // Stray sample with no open frame is dropped and flagged.
    drive(1'b1, 1'b0, 24'd999);
    chk("stray_err", {31'b0, frame_err}, 32'd1);
    repeat (10) begin
      drive(1'b0, 1'b0, '0);
      chk("stray_valid", {31'b0, out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
